// File: rtl/vga_frame_scanner_if.sv
// Signal bundle between the VGA frame scanner, its framebuffer RAM read port and the video DAC.
`timescale 1ns/1ps
interface vga_frame_scanner_if;
    logic [31:0] fb_addr;
    logic [7:0]  fb_data;
    logic        vgaclk;
    logic        hsync;
    logic        vsync;
    logic        sync_b;
    logic        blank_b;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        frame_start;

    modport master (
        output fb_addr,
        input  fb_data,
        output vgaclk, hsync, vsync, sync_b, blank_b, r, g, b, frame_start
    );

    modport slave (
        input  fb_addr,
        output fb_data,
        input  vgaclk, hsync, vsync, sync_b, blank_b, r, g, b, frame_start
    );
endinterface

// File: rtl/vga_frame_scanner.sv
// 640x480@60 VGA timing generator scanning a 4x-upscaled RGB332 framebuffer out of shared data RAM.
`timescale 1ns/1ps
module vga_frame_scanner #(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned FB_W    = 160,
    parameter logic [31:0] FB_BASE = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                reset,
    vga_frame_scanner_if.master vga_bus
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = $clog2(PIX_DIV);
    localparam int unsigned H_W   = $clog2(H_TOT);
    localparam int unsigned V_W   = $clog2(V_TOT);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOT - 1);
    localparam logic [H_W-1:0]   H_VIS_C  = H_W'(H_VIS);
    localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_VIS + H_FP);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOT - 1);
    localparam logic [V_W-1:0]   V_VIS_C  = V_W'(V_VIS);
    localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_VIS + V_FP);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_VIS + V_FP + V_SYNC);

    // RRRGGGBB widened by repeating each field's MSBs into the low bits
    function automatic logic [23:0] rgb332_expand(input logic [7:0] pix);
        rgb332_expand = {pix[7:5], pix[7:5], pix[7:6],
                         pix[4:2], pix[4:2], pix[4:3],
                         pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
    endfunction

    logic [DIV_W-1:0] r_div;
    logic             r_vgaclk;
    logic [H_W-1:0]   r_hcnt;
    logic [V_W-1:0]   r_vcnt;
    logic             r_frame_start;
    logic [31:0]      r_fb_addr;
    logic [1:0]       r_hs_pipe;
    logic [1:0]       r_vs_pipe;
    logic [1:0]       r_bl_pipe;
    logic [7:0]       r_pix;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank_b;
    logic [23:0]      r_rgb;

    logic             w_tick;
    logic [DIV_W-1:0] w_div_next;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_bl_raw;
    logic [31:0]      w_addr;

    // Pixel-tick strobe, raw sync/blank decode and framebuffer address of the current pixel
    always_comb begin
        w_tick = (r_div == DIV_LAST);
        if (w_tick) begin
            w_div_next = {DIV_W{1'b0}};
        end else begin
            w_div_next = r_div + 1'b1;
        end
        w_hs_raw = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
        w_vs_raw = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
        w_bl_raw = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
        w_addr   = FB_BASE + (32'(r_vcnt >> 2'd2) * FB_W) + 32'(r_hcnt >> 2'd2);
    end

    // Pixel divider, vgaclk and the beam position counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div         <= {DIV_W{1'b0}};
            r_vgaclk      <= 1'b0;
            r_hcnt        <= {H_W{1'b0}};
            r_vcnt        <= {V_W{1'b0}};
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_vgaclk      <= (w_div_next >= DIV_HALF);
            r_frame_start <= w_tick && (r_hcnt == {H_W{1'b0}}) && (r_vcnt == {V_W{1'b0}});
            if (w_tick) begin
                if (r_hcnt == H_LAST) begin
                    r_hcnt <= {H_W{1'b0}};
                    if (r_vcnt == V_LAST) begin
                        r_vcnt <= {V_W{1'b0}};
                    end else begin
                        r_vcnt <= r_vcnt + 1'b1;
                    end
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
        end
    end

    // Two-tick pipeline: address out, RAM data back, then colour and sync together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb_addr <= FB_BASE;
            r_hs_pipe <= 2'b11;
            r_vs_pipe <= 2'b11;
            r_bl_pipe <= 2'b00;
            r_pix     <= 8'h00;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_b <= 1'b0;
            r_rgb     <= 24'h00_0000;
        end else if (w_tick) begin
            if (w_bl_raw) begin
                r_fb_addr <= w_addr;
            end
            r_hs_pipe <= {r_hs_pipe[0], w_hs_raw};
            r_vs_pipe <= {r_vs_pipe[0], w_vs_raw};
            r_bl_pipe <= {r_bl_pipe[0], w_bl_raw};
            r_pix     <= vga_bus.fb_data;
            r_hsync   <= r_hs_pipe[1];
            r_vsync   <= r_vs_pipe[1];
            r_blank_b <= r_bl_pipe[1];
            if (r_bl_pipe[1]) begin
                r_rgb <= rgb332_expand(r_pix);
            end else begin
                r_rgb <= 24'h00_0000;
            end
        end
    end

    assign vga_bus.fb_addr     = r_fb_addr;
    assign vga_bus.vgaclk      = r_vgaclk;
    assign vga_bus.hsync       = r_hsync;
    assign vga_bus.vsync       = r_vsync;
    assign vga_bus.sync_b      = 1'b0;
    assign vga_bus.blank_b     = r_blank_b;
    assign vga_bus.r           = r_rgb[23:16];
    assign vga_bus.g           = r_rgb[15:8];
    assign vga_bus.b           = r_rgb[7:0];
    assign vga_bus.frame_start = r_frame_start;
endmodule
